// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage. Holds the program counter and drives an
//   asynchronous-read instruction memory. Each fetched instruction is
//   registered, together with its PC and the following PC, into a single
//   output slot. Decode takes instructions from this slot.
//
//   Ports
//     clk, rst         clock; synchronous active-high reset
//     stall            hazard hold: no new fetch this cycle
//     redirect_valid   taken branch/jump: load redirect_target, flush slot
//     redirect_target  new PC (low bits cleared; flagged if misaligned)
//     imem_addr        instruction memory address (= pc, combinational)
//     imem_rdata       instruction at imem_addr, same cycle
//     out_valid        slot holds a fetched instruction
//     out_ready        decode accepts the slot this cycle
//     out_pc           PC of the slot instruction
//     out_pc_next      out_pc + INSTR_BYTES (wraps modulo 2^ADDR_WIDTH)
//     out_instr        slot instruction
//     misalign_fault   one-cycle pulse after a misaligned redirect
//     fetch_count      saturating count of slots accepted by decode
//
//   Handshake: a slot transfers on any rising edge where
//   out_valid & out_ready. While out_valid=1 and out_ready=0 every out_*
//   signal is held stable and the pc does not advance. out_valid never
//   depends combinationally on out_ready. All out_* are driven from flops.
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int INSTR_BYTES  = 4,
    parameter int RESET_VECTOR = 0,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [ADDR_WIDTH-1:0] out_pc_next,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic                  misalign_fault,
    output logic [CNT_WIDTH-1:0]  fetch_count
);

    // Step and alignment masks are built from INSTR_BYTES directly, so an
    // INSTR_BYTES of 1 (no alignment bits) needs no special-case slicing.
    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(INSTR_BYTES);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK   = STEP - ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~LOW_MASK;
    localparam logic [ADDR_WIDTH-1:0] RST_PC     = ADDR_WIDTH'(RESET_VECTOR);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_plus;
    logic                  accept;
    logic                  load;

    assign imem_addr = pc;
    assign pc_plus   = pc + STEP;
    assign accept    = out_valid & out_ready;
    // The slot can take a new instruction when it is empty or draining now.
    assign load      = ~stall & (~out_valid | out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RST_PC;
            out_valid      <= 1'b0;
            out_pc         <= '0;
            out_pc_next    <= '0;
            out_instr      <= '0;
            misalign_fault <= 1'b0;
            fetch_count    <= '0;
        end else begin
            misalign_fault <= 1'b0;

            // Counting is independent of the priority chain: an accepted
            // slot is counted even when a redirect flushes it.
            if (accept && (fetch_count != CNT_MAX)) begin
                fetch_count <= fetch_count + CNT_WIDTH'(1);
            end

            if (redirect_valid) begin
                pc             <= redirect_target & ALIGN_MASK;
                out_valid      <= 1'b0;
                misalign_fault <= |(redirect_target & LOW_MASK);
            end else if (load) begin
                out_pc      <= pc;
                out_pc_next <= pc_plus;
                out_instr   <= imem_rdata;
                out_valid   <= 1'b1;
                pc          <= pc_plus;
            end else if (accept) begin
                // Stalled while decode drains the slot: leave a bubble.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. Two instances share all inputs: the main
//   one (32-bit counter) and a narrow-counter one (4-bit) for saturation.
//   The instruction memory returns {16'hA5A5, address} so every slot word
//   identifies the address it was fetched from.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          redirect_valid;
    logic [AW-1:0] redirect_target;
    logic          out_ready;

    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          out_valid;
    logic [AW-1:0] out_pc;
    logic [AW-1:0] out_pc_next;
    logic [DW-1:0] out_instr;
    logic          misalign_fault;
    logic [31:0]   fetch_count;

    logic [AW-1:0] s_imem_addr;
    logic [DW-1:0] s_imem_rdata;
    logic          s_out_valid;
    logic [AW-1:0] s_out_pc;
    logic [AW-1:0] s_out_pc_next;
    logic [DW-1:0] s_out_instr;
    logic          s_misalign_fault;
    logic [3:0]    s_fetch_count;

    int errors = 0;
    int checks = 0;

    assign imem_rdata   = {16'hA5A5, imem_addr};
    assign s_imem_rdata = {16'hA5A5, s_imem_addr};

    fetch_unit #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INSTR_BYTES(4),
        .RESET_VECTOR(16'h0100), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_pc_next(out_pc_next), .out_instr(out_instr),
        .misalign_fault(misalign_fault), .fetch_count(fetch_count)
    );

    fetch_unit #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INSTR_BYTES(4),
        .RESET_VECTOR(16'h0100), .CNT_WIDTH(4)
    ) dut_sat (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_addr(s_imem_addr), .imem_rdata(s_imem_rdata),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_pc(s_out_pc), .out_pc_next(s_out_pc_next), .out_instr(s_out_instr),
        .misalign_fault(s_misalign_fault), .fetch_count(s_fetch_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs are driven and outputs
    // sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 16'h0200;
        repeat (3) step();
        checks++;
        if ({imem_addr, out_valid, misalign_fault} !== {16'h0100, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: pc=%h valid=%b mis=%b, want pc=0100 valid=0 mis=0",
                     imem_addr, out_valid, misalign_fault);
        end
        checks++;
        if ({fetch_count, s_fetch_count, out_pc, out_pc_next, out_instr} !== 100'd0) begin
            errors++;
            $display("FAIL reset_slot: cnt=%0d scnt=%0d pc=%h nxt=%h ins=%h, want all 0",
                     fetch_count, s_fetch_count, out_pc, out_pc_next, out_instr);
        end
        rst = 1'b0; redirect_valid = 1'b0; redirect_target = 16'h0000;
        step();
        checks++;
        if ({out_valid, out_pc, out_pc_next, out_instr, imem_addr} !==
            {1'b1, 16'h0100, 16'h0104, 32'hA5A50100, 16'h0104}) begin
            errors++;
            $display("FAIL first_slot: v=%b pc=%h nxt=%h ins=%h imem=%h, want 1 0100 0104 a5a50100 0104",
                     out_valid, out_pc, out_pc_next, out_instr, imem_addr);
        end
    endtask

    task automatic test_streaming();
        logic [AW-1:0] exp_pc;
        out_ready = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            step();
            exp_pc = 16'h0100 + AW'(4 * k);
            checks++;
            if ({out_valid, out_pc, out_instr, fetch_count} !==
                {1'b1, exp_pc, 16'hA5A5, exp_pc, 32'(k)}) begin
                errors++;
                $display("FAIL stream_%0d: v=%b pc=%h ins=%h cnt=%0d, want 1 %h a5a5%h %0d",
                         k, out_valid, out_pc, out_instr, fetch_count, exp_pc, exp_pc, k);
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({out_valid, out_pc, out_pc_next, out_instr, imem_addr, fetch_count} !==
                {1'b1, 16'h0108, 16'h010C, 32'hA5A50108, 16'h010C, 32'd2}) begin
                errors++;
                $display("FAIL hold_%0d: v=%b pc=%h nxt=%h ins=%h imem=%h cnt=%0d, want 1 0108 010c a5a50108 010c 2",
                         k, out_valid, out_pc, out_pc_next, out_instr, imem_addr, fetch_count);
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({out_valid, out_pc, imem_addr, fetch_count} !== {1'b1, 16'h010C, 16'h0110, 32'd3}) begin
            errors++;
            $display("FAIL release: v=%b pc=%h imem=%h cnt=%0d, want 1 010c 0110 3",
                     out_valid, out_pc, imem_addr, fetch_count);
        end
        step();
        checks++;
        if ({out_pc, fetch_count} !== {16'h0110, 32'd4}) begin
            errors++;
            $display("FAIL after_release: pc=%h cnt=%0d, want 0110 4", out_pc, fetch_count);
        end
    endtask

    task automatic test_redirect();
        // Misaligned target while the slot 0x110 is being accepted.
        redirect_valid = 1'b1; redirect_target = 16'h0042;
        step();
        checks++;
        if ({misalign_fault, out_valid, imem_addr, fetch_count} !== {1'b1, 1'b0, 16'h0040, 32'd5}) begin
            errors++;
            $display("FAIL redir_mis: mis=%b v=%b imem=%h cnt=%0d, want 1 0 0040 5",
                     misalign_fault, out_valid, imem_addr, fetch_count);
        end
        redirect_valid = 1'b0; redirect_target = 16'h0000;
        step();
        checks++;
        if ({misalign_fault, out_valid, out_pc, out_instr, fetch_count} !==
            {1'b0, 1'b1, 16'h0040, 32'hA5A50040, 32'd5}) begin
            errors++;
            $display("FAIL redir_slot: mis=%b v=%b pc=%h ins=%h cnt=%0d, want 0 1 0040 a5a50040 5",
                     misalign_fault, out_valid, out_pc, out_instr, fetch_count);
        end
        // Aligned target: no fault pulse.
        redirect_valid = 1'b1; redirect_target = 16'h0080;
        step();
        checks++;
        if ({misalign_fault, out_valid, imem_addr, fetch_count} !== {1'b0, 1'b0, 16'h0080, 32'd6}) begin
            errors++;
            $display("FAIL redir_align: mis=%b v=%b imem=%h cnt=%0d, want 0 0 0080 6",
                     misalign_fault, out_valid, imem_addr, fetch_count);
        end
    endtask

    task automatic test_stall_wrap();
        redirect_valid = 1'b1; redirect_target = 16'hFFF8;
        step();
        redirect_valid = 1'b0; redirect_target = 16'h0000;
        step();
        checks++;
        if ({out_valid, out_pc, imem_addr, fetch_count} !== {1'b1, 16'hFFF8, 16'hFFFC, 32'd6}) begin
            errors++;
            $display("FAIL pre_wrap: v=%b pc=%h imem=%h cnt=%0d, want 1 fff8 fffc 6",
                     out_valid, out_pc, imem_addr, fetch_count);
        end
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if ({out_valid, imem_addr, fetch_count} !== {1'b0, 16'hFFFC, 32'd7}) begin
                errors++;
                $display("FAIL stall_%0d: v=%b imem=%h cnt=%0d, want 0 fffc 7",
                         k, out_valid, imem_addr, fetch_count);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if ({out_valid, out_pc, out_pc_next, out_instr, imem_addr, misalign_fault} !==
            {1'b1, 16'hFFFC, 16'h0000, 32'hA5A5FFFC, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL wrap: v=%b pc=%h nxt=%h ins=%h imem=%h mis=%b, want 1 fffc 0000 a5a5fffc 0000 0",
                     out_valid, out_pc, out_pc_next, out_instr, imem_addr, misalign_fault);
        end
        // Stall and redirect together: redirect wins, accepted slot counted.
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 16'h0100;
        step();
        checks++;
        if ({out_valid, imem_addr, fetch_count} !== {1'b0, 16'h0100, 32'd8}) begin
            errors++;
            $display("FAIL stall_redir: v=%b imem=%h cnt=%0d, want 0 0100 8",
                     out_valid, imem_addr, fetch_count);
        end
        stall = 1'b0; redirect_valid = 1'b0; redirect_target = 16'h0000;
        step();
        checks++;
        if ({out_valid, out_pc, fetch_count} !== {1'b1, 16'h0100, 32'd8}) begin
            errors++;
            $display("FAIL post_stall_redir: v=%b pc=%h cnt=%0d, want 1 0100 8",
                     out_valid, out_pc, fetch_count);
        end
    endtask

    task automatic test_saturation();
        checks++;
        if (s_fetch_count !== 4'd8) begin
            errors++;
            $display("FAIL sat_start: got %0d want 8", s_fetch_count);
        end
        out_ready = 1'b1;
        repeat (20) step();
        checks++;
        if ({s_fetch_count, fetch_count, out_pc} !== {4'd15, 32'd28, 16'h0150}) begin
            errors++;
            $display("FAIL saturate: scnt=%0d cnt=%0d pc=%h, want 15 28 0150",
                     s_fetch_count, fetch_count, out_pc);
        end
    endtask

    task automatic test_reset_mid_stall();
        stall = 1'b1; rst = 1'b1;
        step();
        checks++;
        if ({imem_addr, out_valid, fetch_count, s_fetch_count} !== {16'h0100, 1'b0, 32'd0, 4'd0}) begin
            errors++;
            $display("FAIL reset_mid: imem=%h v=%b cnt=%0d scnt=%0d, want 0100 0 0 0",
                     imem_addr, out_valid, fetch_count, s_fetch_count);
        end
        rst = 1'b0; stall = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect();
        test_stall_wrap();
        test_saturation();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
